// File: rtl/multi_motor_step_gen_pkg.sv
// Shared types and default widths for the multi-axis step/dir generator.
package multi_motor_step_gen_pkg;

    localparam int DEF_N_AXES = 4;
    localparam int DEF_TW     = 32;
    localparam int POS_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        PULSE = 2'd2,
        POST  = 2'd3
    } step_state_e;

endpackage

// File: rtl/motor_step_channel.sv
// One step/dir channel: dir setup -> step high -> step low hold, with a
// one-deep pending request slot and a sticky overrun flag.
// Optional position counter: MULTI_MOTOR_STEP_GEN_POSITION_EN.
module motor_step_channel
    import multi_motor_step_gen_pkg::*;
#(
    parameter int TW = DEF_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] pre_n,
    input  logic [TW-1:0] pulse_n,
    input  logic [TW-1:0] post_n,
    input  logic          axis_en,
    input  logic          dir_invert,
    input  logic          step_stb,
    input  logic          step_dir,
    input  logic          clear_missed,
`ifdef MULTI_MOTOR_STEP_GEN_POSITION_EN
    input  logic          pos_clear,
    output logic [31:0]   position,
`endif
    output logic          step,
    output logic          dir,
    output logic          busy,
    output logic          missed
);

    // Zero-length phases still last one cycle; counter counts down to 0.
    function automatic logic [TW-1:0] len1(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    step_state_e   r_state, w_nstate;
    logic [TW-1:0] r_cnt, w_ncnt;
    logic [TW-1:0] r_pulse_len, r_post_len;
    logic          r_mv_dir, r_dir, r_pend, r_pend_dir, r_missed;
    logic          w_last, w_start, w_start_dir, w_consume;
    logic          w_stb_direct, w_stb_extra, w_pulse_entry;

    assign w_last = (r_cnt == '0);
    // A move starts from IDLE, or back-to-back from the last POST cycle.
    // A strobe arriving on the last POST cycle with no slot chains directly.
    assign w_start = axis_en && (r_pend || step_stb) &&
                     ((r_state == IDLE) || ((r_state == POST) && w_last));
    assign w_start_dir  = r_pend ? r_pend_dir : step_dir;
    assign w_consume    = w_start && r_pend;
    assign w_stb_direct = w_start && !r_pend && step_stb;
    assign w_stb_extra  = axis_en && step_stb && !w_stb_direct;

    // Next-state and phase counter reload.
    always_comb begin
        w_nstate      = r_state;
        w_ncnt        = r_cnt;
        w_pulse_entry = 1'b0;
        if (!axis_en) begin
            w_nstate = IDLE;
            w_ncnt   = '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_start) begin
                    w_nstate = PRE;
                    w_ncnt   = len1(pre_n);
                end
                PRE: if (w_last) begin
                    w_nstate      = PULSE;
                    w_ncnt        = len1(r_pulse_len);
                    w_pulse_entry = 1'b1;
                end else w_ncnt = r_cnt - TW'(1);
                PULSE: if (w_last) begin
                    w_nstate = POST;
                    w_ncnt   = len1(r_post_len);
                end else w_ncnt = r_cnt - TW'(1);
                POST: if (w_last) begin
                    w_nstate = w_start ? PRE : IDLE;
                    w_ncnt   = w_start ? len1(pre_n) : '0;
                end else w_ncnt = r_cnt - TW'(1);
                default: w_nstate = IDLE;
            endcase
        end
    end

    // State, counter, and per-move latched lengths/direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pulse_len <= '0;
            r_post_len  <= '0;
            r_mv_dir    <= 1'b0;
            r_dir       <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            if (w_start) begin
                r_pulse_len <= pulse_n;
                r_post_len  <= post_n;
                r_mv_dir    <= w_start_dir;
                r_dir       <= w_start_dir ^ dir_invert;
            end
        end
    end

    // Pending slot and sticky missed flag; a slot consumed this cycle may refill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= 1'b0;
            r_pend_dir <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            if (!axis_en) begin
                r_pend <= 1'b0;
            end else if (w_stb_extra && (!r_pend || w_consume)) begin
                r_pend     <= 1'b1;
                r_pend_dir <= step_dir;
            end else if (w_consume) begin
                r_pend <= 1'b0;
            end
            if (w_stb_extra && r_pend && !w_consume) r_missed <= 1'b1;
            else if (clear_missed)                   r_missed <= 1'b0;
        end
    end

`ifdef MULTI_MOTOR_STEP_GEN_POSITION_EN
    logic [31:0] r_pos;
    // Signed step count, updated as each pulse begins; clear still counts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos <= '0;
        end else if (pos_clear) begin
            r_pos <= w_pulse_entry ? (r_mv_dir ? 32'd1 : 32'hFFFF_FFFF) : 32'd0;
        end else if (w_pulse_entry) begin
            r_pos <= r_mv_dir ? r_pos + 32'd1 : r_pos - 32'd1;
        end
    end
    assign position = r_pos;
`endif

    assign step   = (r_state == PULSE);
    assign busy   = (r_state != IDLE);
    assign dir    = r_dir;
    assign missed = r_missed;

endmodule

// File: rtl/multi_motor_step_gen.sv
// N_AXES independent step/dir generators sharing phase-length inputs.
// Optional position counters: MULTI_MOTOR_STEP_GEN_POSITION_EN.
module multi_motor_step_gen
    import multi_motor_step_gen_pkg::*;
#(
    parameter int N_AXES = DEF_N_AXES,
    parameter int TW     = DEF_TW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TW-1:0]       pre_n,
    input  logic [TW-1:0]       pulse_n,
    input  logic [TW-1:0]       post_n,
    input  logic [N_AXES-1:0]   axis_en,
    input  logic [N_AXES-1:0]   dir_invert,
    input  logic [N_AXES-1:0]   step_stb,
    input  logic [N_AXES-1:0]   step_dir,
    input  logic [N_AXES-1:0]   clear_missed,
`ifdef MULTI_MOTOR_STEP_GEN_POSITION_EN
    input  logic [N_AXES-1:0]   pos_clear,
    output logic [32*N_AXES-1:0] position,
`endif
    output logic [N_AXES-1:0]   step,
    output logic [N_AXES-1:0]   dir,
    output logic [N_AXES-1:0]   busy,
    output logic [N_AXES-1:0]   missed
);

    for (genvar g = 0; g < N_AXES; g++) begin : g_ch
        motor_step_channel #(.TW(TW)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .pre_n        (pre_n),
            .pulse_n      (pulse_n),
            .post_n       (post_n),
            .axis_en      (axis_en[g]),
            .dir_invert   (dir_invert[g]),
            .step_stb     (step_stb[g]),
            .step_dir     (step_dir[g]),
            .clear_missed (clear_missed[g]),
`ifdef MULTI_MOTOR_STEP_GEN_POSITION_EN
            .pos_clear    (pos_clear[g]),
            .position     (position[32*g +: 32]),
`endif
            .step         (step[g]),
            .dir          (dir[g]),
            .busy         (busy[g]),
            .missed       (missed[g])
        );
    end

endmodule

// File: tb/tb_multi_motor_step_gen.sv
// Directed bench: expected pulses (axis, rise cycle, dir) go to a scoreboard
// when strobes are driven; a negedge monitor pops them as step rises.
module tb_multi_motor_step_gen;
    localparam int N  = 4;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [TW-1:0] pre_n, pulse_n, post_n;
    logic [N-1:0]  axis_en, dir_invert, step_stb, step_dir, clear_missed;
    logic [N-1:0]  step, dir, busy, missed;
`ifdef MULTI_MOTOR_STEP_GEN_POSITION_EN
    logic [N-1:0]    pos_clear;
    logic [32*N-1:0] position;
`endif

    multi_motor_step_gen #(.N_AXES(N), .TW(TW)) dut (
        .clk(clk), .reset(reset),
        .pre_n(pre_n), .pulse_n(pulse_n), .post_n(post_n),
        .axis_en(axis_en), .dir_invert(dir_invert),
        .step_stb(step_stb), .step_dir(step_dir), .clear_missed(clear_missed),
`ifdef MULTI_MOTOR_STEP_GEN_POSITION_EN
        .pos_clear(pos_clear), .position(position),
`endif
        .step(step), .dir(dir), .busy(busy), .missed(missed)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int mis = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   axis;
        int   rise;
        logic dir;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int rise, input logic d);
        exp_t e;
        e.axis = a; e.rise = rise; e.dir = d;
        sb.push_back(e);
    endtask

    function automatic int find_exp(input int a);
        foreach (sb[i]) if (sb[i].axis == a) return i;
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse monitor: every rising step must match the oldest expectation for its axis.
    logic [N-1:0] step_q = '0;
    int idx_m;
    always @(negedge clk) begin
        for (int a = 0; a < N; a++) begin
            if (step[a] && !step_q[a]) begin
                idx_m = find_exp(a);
                chk($sformatf("pulse_expected_ax%0d", a), 32'(idx_m >= 0), 32'd1);
                if (idx_m >= 0) begin
                    chk($sformatf("rise_cycle_ax%0d", a), 32'(cyc), 32'(sb[idx_m].rise));
                    chk($sformatf("rise_dir_ax%0d", a), 32'(dir[a]), 32'(sb[idx_m].dir));
                    sb.delete(idx_m);
                end
            end
        end
        step_q <= step;
    end

    initial begin
        reset = 1'b1;
        pre_n = '0; pulse_n = '0; post_n = '0;
        axis_en = '0; dir_invert = '0; step_stb = '0; step_dir = '0; clear_missed = '0;
`ifdef MULTI_MOTOR_STEP_GEN_POSITION_EN
        pos_clear = '0;
`endif
        tick(2);
        chk("rst_step", 32'(step), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_missed", 32'(missed), 0);
        reset = 1'b0;
        axis_en = '1;
        tick(1);

        // Basic timing: pre=2, pulse=3, post=4 on axis 0.
        pre_n = 2; pulse_n = 3; post_n = 4;
        push(0, cyc + 3, 1'b1);
        step_stb = 4'b0001; step_dir = 4'b0001;
        tick(1); step_stb = '0; step_dir = '0;
        chk("t1_dir_p1", 32'(dir[0]), 1);
        chk("t1_busy_p1", 32'(busy[0]), 1);
        chk("t1_step_p1", 32'(step[0]), 0);
        tick(1); chk("t1_step_p2", 32'(step[0]), 0);
        tick(1); chk("t1_step_p3", 32'(step[0]), 1);
        tick(2); chk("t1_step_p5", 32'(step[0]), 1);
        tick(1); chk("t1_step_p6", 32'(step[0]), 0);
        tick(3); chk("t1_busy_p9", 32'(busy[0]), 1);
        tick(1); chk("t1_busy_p10", 32'(busy[0]), 0);

        // Zero lengths: every phase one cycle.
        pre_n = 0; pulse_n = 0; post_n = 0;
        push(0, cyc + 2, 1'b0);
        step_stb = 4'b0001;
        tick(1); step_stb = '0;
        chk("t2_busy_p1", 32'(busy[0]), 1);
        chk("t2_step_p1", 32'(step[0]), 0);
        tick(1); chk("t2_step_p2", 32'(step[0]), 1);
        tick(1); chk("t2_step_p3", 32'(step[0]), 0);
        chk("t2_busy_p3", 32'(busy[0]), 1);
        tick(1); chk("t2_busy_p4", 32'(busy[0]), 0);
        chk("t2_dir", 32'(dir[0]), 0);

        // Pending slot and overrun on axis 1.
        pre_n = 2; pulse_n = 3; post_n = 4;
        push(1, cyc + 3, 1'b1);
        push(1, cyc + 12, 1'b0);
        step_stb = 4'b0010; step_dir = 4'b0010;
        tick(1); step_dir = 4'b0000;              // PRE: fills slot with dir 0
        tick(1); step_stb = '0;
        chk("t3_missed_after_pre", 32'(missed[1]), 0);
        tick(1); step_stb = 4'b0010; step_dir = 4'b0010; // PULSE: slot full
        tick(1); step_stb = '0; step_dir = '0;
        chk("t3_missed_set", 32'(missed[1]), 1);
        clear_missed = 4'b0010;
        tick(1); clear_missed = '0;
        chk("t3_missed_cleared", 32'(missed[1]), 0);
        tick(13); chk("t3_busy_p18", 32'(busy[1]), 1);
        tick(1); chk("t3_busy_p19", 32'(busy[1]), 0);
        chk("t3_missed_final", 32'(missed[1]), 0);

        // Dir invert and disable mid-PULSE on axis 2.
        pre_n = 1; pulse_n = 3; post_n = 1;
        dir_invert = 4'b0100;
        push(2, cyc + 2, 1'b1);
        step_stb = 4'b0100; step_dir = 4'b0000;
        tick(1); step_stb = '0;
        chk("t4_dir_inv", 32'(dir[2]), 1);
        tick(1); chk("t4_step_p2", 32'(step[2]), 1);
        axis_en = 4'b1011;
        tick(1);
        chk("t4_step_off", 32'(step[2]), 0);
        chk("t4_busy_off", 32'(busy[2]), 0);
        chk("t4_dir_hold", 32'(dir[2]), 1);
        step_stb = 4'b0100;
        tick(1); step_stb = '0;
        chk("t4_missed_dis", 32'(missed[2]), 0);
        chk("t4_busy_dis", 32'(busy[2]), 0);
        axis_en = '1; dir_invert = '0;
        tick(1);

        // Asynchronous reset in the middle of PULSE on all axes.
        pre_n = 1; pulse_n = 4; post_n = 1;
        for (int a = 0; a < N; a++) push(a, cyc + 2, 1'b1);
        step_stb = '1; step_dir = '1;
        tick(1); step_stb = '0; step_dir = '0;
        tick(1); chk("t5_step_all", 32'(step), 32'hF);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t5_async_step", 32'(step), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_dir", 32'(dir), 0);
        chk("t5_async_missed", 32'(missed), 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_idle_step", 32'(step), 0);

`ifdef MULTI_MOTOR_STEP_GEN_POSITION_EN
        // Position: +5 -2 = 3, then clear with a concurrent dir=0 pulse -> -1.
        pre_n = 0; pulse_n = 0; post_n = 0;
        for (int k = 0; k < 7; k++) begin
            push(3, cyc + 2, (k < 5));
            step_stb = 4'b1000; step_dir = (k < 5) ? 4'b1000 : 4'b0000;
            tick(1); step_stb = '0; step_dir = '0;
            tick(3);
        end
        chk("pos_plus3", position[127:96], 32'd3);
        push(3, cyc + 2, 1'b0);
        step_stb = 4'b1000; step_dir = 4'b0000;
        tick(1); step_stb = '0;
        pos_clear = 4'b1000;
        tick(1); pos_clear = '0;
        chk("pos_clear_minus1", position[127:96], 32'hFFFF_FFFF);
        tick(3);
`endif

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
